// File: rtl/rc_la_pipe_if.sv
// Per-channel request/result bundle between the input buffers and the lookahead route stage.
interface rc_la_pipe_if #(
    parameter int NUM_CH = 4,
    parameter int DST_W  = 6
);
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH*DST_W-1:0] in_dst;
    logic [NUM_CH*2-1:0]     in_outdir;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH*5-1:0]     out_pref;
    logic [NUM_CH-1:0]       out_err;
    logic [NUM_CH-1:0]       out_ready;

    modport master (
        output in_valid, in_dst, in_outdir, out_ready,
        input  in_ready, out_valid, out_pref, out_err
    );

    modport slave (
        input  in_valid, in_dst, in_outdir, out_ready,
        output in_ready, out_valid, out_pref, out_err
    );
endinterface

// File: rtl/rc_la_pipe.sv
// Lookahead route computation: preferred-port vector at the neighbour (or this node) per channel.
// Latency 1 cycle, one result register per channel.
// Backpressure: in_ready[c] = !out_valid[c] || out_ready[c]; held result is stable while stalled.
module rc_la_pipe #(
    parameter int NUM_CH     = 4,
    parameter int COORD_W    = 3,
    parameter int MESH_X     = 8,
    parameter int MESH_Y     = 8,
    parameter int CURR_X     = 0,
    parameter int CURR_Y     = 0,
    parameter int ROUTE_MODE = 0,
    parameter int LOOKAHEAD  = 1,
    parameter int ERRC_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    rc_la_pipe_if.slave       bus,
    output logic [ERRC_W-1:0] err_count
);
    localparam int DST_W = 2 * COORD_W;
    // Two guard bits: one for the sign, one so CURR+1 at the top coordinate cannot alias negative.
    localparam int CW    = COORD_W + 2;
    localparam int SUM_W = ERRC_W + $clog2(NUM_CH + 1);

    typedef logic signed [CW-1:0] crd_t;

    typedef struct packed {
        logic       err;
        logic [4:0] pref;
    } res_t;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    localparam int P_N = 0;
    localparam int P_E = 1;
    localparam int P_S = 2;
    localparam int P_W = 3;
    localparam int P_L = 4;

    localparam crd_t CX  = crd_t'(CURR_X);
    localparam crd_t CY  = crd_t'(CURR_Y);
    localparam crd_t MX  = crd_t'(MESH_X);
    localparam crd_t MY  = crd_t'(MESH_Y);
    localparam crd_t ONE = crd_t'(1);

    logic [NUM_CH-1:0] err_acc;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DST_W-1:0] dst;
        dir_t             dir;
        crd_t             dx;
        crd_t             dy;
        crd_t             nx;
        crd_t             ny;
        logic             off_mesh;
        logic             acc;
        logic             vld;
        res_t             res_d;
        res_t             res_q;

        assign dst = bus.in_dst[c*DST_W +: DST_W];
        assign dir = dir_t'(bus.in_outdir[c*2 +: 2]);
        assign dx  = crd_t'({2'b00, dst[COORD_W-1:0]});
        assign dy  = crd_t'({2'b00, dst[DST_W-1:COORD_W]});

        always_comb begin
            nx = CX;
            ny = CY;
            if (LOOKAHEAD != 0) begin
                case (dir)
                    DIR_N:   ny = CY + ONE;
                    DIR_E:   nx = CX + ONE;
                    DIR_S:   ny = CY - ONE;
                    default: nx = CX - ONE;
                endcase
            end
        end

        assign off_mesh = nx[CW-1] | ny[CW-1] | (nx >= MX) | (ny >= MY) |
                          (dx >= MX) | (dy >= MY);

        always_comb begin
            res_d = '0;
            if (off_mesh) begin
                res_d.err = 1'b1;
            end else if ((dx == nx) && (dy == ny)) begin
                res_d.pref[P_L] = 1'b1;
            end else begin
                case (ROUTE_MODE)
                    1: begin
                        res_d.pref[P_N] = dy > ny;
                        res_d.pref[P_S] = dy < ny;
                        if (dy == ny) begin
                            res_d.pref[P_E] = dx > nx;
                            res_d.pref[P_W] = dx < nx;
                        end
                    end
                    2: begin
                        // West moves must come first; once no west hop remains, any productive turn is allowed.
                        if (dx < nx) begin
                            res_d.pref[P_W] = 1'b1;
                        end else begin
                            res_d.pref[P_E] = dx > nx;
                            res_d.pref[P_N] = dy > ny;
                            res_d.pref[P_S] = dy < ny;
                        end
                    end
                    default: begin
                        res_d.pref[P_E] = dx > nx;
                        res_d.pref[P_W] = dx < nx;
                        if (dx == nx) begin
                            res_d.pref[P_N] = dy > ny;
                            res_d.pref[P_S] = dy < ny;
                        end
                    end
                endcase
            end
        end

        assign acc = bus.in_valid[c] & bus.in_ready[c];

        always_ff @(posedge clk) begin
            if (reset) begin
                vld   <= 1'b0;
                res_q <= '0;
            end else if (acc) begin
                vld   <= 1'b1;
                res_q <= res_d;
            end else if (bus.out_ready[c]) begin
                vld   <= 1'b0;
            end
        end

        assign bus.in_ready[c]         = ~vld | bus.out_ready[c];
        assign bus.out_valid[c]        = vld;
        assign bus.out_pref[c*5 +: 5]  = res_q.pref;
        assign bus.out_err[c]          = res_q.err;
        assign err_acc[c]              = acc & res_d.err;
    end

    logic [SUM_W-1:0]  err_sum;
    logic [ERRC_W-1:0] err_count_d;

    always_comb begin
        err_sum = SUM_W'(err_count);
        for (int c = 0; c < NUM_CH; c++) begin
            err_sum = err_sum + SUM_W'(err_acc[c]);
        end
        if (err_sum > SUM_W'({ERRC_W{1'b1}})) begin
            err_count_d = '1;
        end else begin
            err_count_d = err_sum[ERRC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else begin
            err_count <= err_count_d;
        end
    end
endmodule

// File: tb/tb_rc_la_pipe.sv
// Five differently-configured route stages driven by directed and random traffic,
// each checked every cycle against an integer-arithmetic routing model.
module tb_rc_la_pipe;
    localparam int NI = 5;
    localparam int P_MODE [NI] = '{0, 0, 2, 0, 1};
    localparam int P_LA   [NI] = '{1, 0, 0, 1, 1};
    localparam int P_CX   [NI] = '{2, 2, 3, 0, 5};
    localparam int P_CY   [NI] = '{2, 2, 3, 0, 4};
    localparam int P_MX   [NI] = '{8, 8, 8, 8, 6};
    localparam int P_MY   [NI] = '{8, 8, 8, 8, 5};
    localparam int P_CW   [NI] = '{3, 3, 3, 4, 3};
    localparam int P_EW   [NI] = '{16, 16, 16, 2, 16};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  s_vld  [NI];
    logic [3:0]  s_ordy [NI];
    logic [7:0]  s_dst  [NI][4];
    logic [1:0]  s_dir  [NI][4];
    logic [3:0]  o_vld  [NI];
    logic [3:0]  o_rdy  [NI];
    logic [3:0]  o_err  [NI];
    logic [19:0] o_pref [NI];
    logic [15:0] o_ec   [NI];

    int errors = 0;
    int checks = 0;

    function automatic logic [5:0] route(int mode, int la, int cx, int cy, int mx, int my,
                                         int dx, int dy, int dir);
        int nx = cx;
        int ny = cy;
        logic [4:0] p = 5'b0;
        if (la != 0) begin
            if (dir == 0) ny = ny + 1;
            else if (dir == 1) nx = nx + 1;
            else if (dir == 2) ny = ny - 1;
            else nx = nx - 1;
        end
        if (nx < 0 || ny < 0 || nx >= mx || ny >= my || dx >= mx || dy >= my) return 6'b100000;
        if (dx == nx && dy == ny) return 6'b010000;
        if (mode == 1) begin
            p[0] = dy > ny; p[2] = dy < ny;
            if (dy == ny) begin p[1] = dx > nx; p[3] = dx < nx; end
        end else if (mode == 2) begin
            if (dx < nx) p[3] = 1'b1;
            else begin p[1] = dx > nx; p[0] = dy > ny; p[2] = dy < ny; end
        end else begin
            p[1] = dx > nx; p[3] = dx < nx;
            if (dx == nx) begin p[0] = dy > ny; p[2] = dy < ny; end
        end
        return {1'b0, p};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar k = 0; k < NI; k++) begin : g_i
        localparam int CW = P_CW[k];
        localparam int DW = 2 * CW;
        localparam int EW = P_EW[k];

        rc_la_pipe_if #(.NUM_CH(4), .DST_W(DW)) ifc ();
        logic [EW-1:0] ec;

        rc_la_pipe #(
            .NUM_CH(4), .COORD_W(CW), .MESH_X(P_MX[k]), .MESH_Y(P_MY[k]),
            .CURR_X(P_CX[k]), .CURR_Y(P_CY[k]), .ROUTE_MODE(P_MODE[k]),
            .LOOKAHEAD(P_LA[k]), .ERRC_W(EW)
        ) dut (
            .clk(clk), .reset(rst), .bus(ifc), .err_count(ec)
        );

        assign ifc.in_valid  = s_vld[k];
        assign ifc.out_ready = s_ordy[k];
        for (genvar c = 0; c < 4; c++) begin : g_c
            assign ifc.in_dst[c*DW +: DW]  = s_dst[k][c][DW-1:0];
            assign ifc.in_outdir[c*2 +: 2] = s_dir[k][c];
        end
        assign o_vld[k]  = ifc.out_valid;
        assign o_rdy[k]  = ifc.in_ready;
        assign o_err[k]  = ifc.out_err;
        assign o_pref[k] = ifc.out_pref;
        assign o_ec[k]   = 16'(ec);

        // Reference: one held result per channel plus a saturating error tally.
        logic [3:0] m_vld = 4'b0;
        logic [5:0] m_res [4];
        int         m_cnt = 0;
        int         n;
        logic [5:0] r;
        logic       ok;

        always @(posedge clk) begin
            n = m_cnt;
            if (rst) begin
                m_vld <= 4'b0;
                m_cnt <= 0;
            end else begin
                for (int c = 0; c < 4; c++) begin
                    r = route(P_MODE[k], P_LA[k], P_CX[k], P_CY[k], P_MX[k], P_MY[k],
                              int'(s_dst[k][c][CW-1:0]), int'(s_dst[k][c][DW-1:CW]),
                              int'(s_dir[k][c]));
                    if (s_vld[k][c] && (!m_vld[c] || s_ordy[k][c])) begin
                        m_vld[c] <= 1'b1;
                        m_res[c] <= r;
                        if (r[5]) n = n + 1;
                    end else if (s_ordy[k][c]) begin
                        m_vld[c] <= 1'b0;
                    end
                end
                m_cnt <= (n > (1 << EW) - 1) ? (1 << EW) - 1 : n;
            end
        end

        always @(negedge clk) begin
            ok = (o_vld[k] === m_vld) && (o_rdy[k] === (~m_vld | s_ordy[k])) &&
                 (o_ec[k] === 16'(m_cnt));
            for (int c = 0; c < 4; c++) begin
                if (m_vld[c] && ({o_err[k][c], o_pref[k][c*5 +: 5]} !== m_res[c])) ok = 1'b0;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL model_cmp inst %0d t=%0t: got vld=%b rdy=%b err=%b pref=%h ec=%0d expected vld=%b ec=%0d res0..3=%h %h %h %h",
                         k, $time, o_vld[k], o_rdy[k], o_err[k], o_pref[k], o_ec[k], m_vld, m_cnt,
                         m_res[0], m_res[1], m_res[2], m_res[3]);
            end
        end
    end

    task automatic idle();
        for (int k = 0; k < NI; k++) begin
            s_vld[k]  = 4'b0;
            s_ordy[k] = 4'hF;
            for (int c = 0; c < 4; c++) begin
                s_dst[k][c] = 8'h00;
                s_dir[k][c] = 2'd0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("reset_out_valid", 32'(o_vld[0]), 32'h0);
        chk("reset_err_count", 32'(o_ec[3]), 32'h0);

        // Local-mode XY at (2,2): dst (x2,y5) is straight north.
        s_vld[1][0] = 1'b1; s_dst[1][0] = 8'h2A;
        step();
        chk("t1_valid", 32'(o_vld[1][0]), 32'h1);
        chk("t1_pref", 32'(o_pref[1][4:0]), 32'h01);
        chk("t1_err", 32'(o_err[1][0]), 32'h0);
        idle(); step();

        // Lookahead XY: dst (x4,y5) seen from east and north neighbours.
        s_vld[0][0] = 1'b1; s_dst[0][0] = 8'h2C; s_dir[0][0] = 2'd1;
        s_vld[0][1] = 1'b1; s_dst[0][1] = 8'h2C; s_dir[0][1] = 2'd0;
        step();
        chk("t2_east_pref", 32'(o_pref[0][4:0]), 32'h02);
        chk("t2_north_pref", 32'(o_pref[0][9:5]), 32'h02);
        idle(); step();

        // Corner router: west step leaves the mesh; dst x=9 is outside an 8-wide mesh.
        s_vld[3][0] = 1'b1; s_dst[3][0] = 8'h00; s_dir[3][0] = 2'd3;
        step();
        chk("t3_offmesh_err", 32'(o_err[3][0]), 32'h1);
        chk("t3_offmesh_pref", 32'(o_pref[3][4:0]), 32'h0);
        chk("t3_count1", 32'(o_ec[3]), 32'h1);
        s_dst[3][0] = 8'h09; s_dir[3][0] = 2'd1;
        step();
        chk("t3_dst_range_err", 32'(o_err[3][0]), 32'h1);
        chk("t3_count2", 32'(o_ec[3]), 32'h2);
        s_vld[3] = 4'hF;
        for (int c = 0; c < 4; c++) begin s_dst[3][c] = 8'h00; s_dir[3][c] = 2'd3; end
        step();
        chk("t6_saturate", 32'(o_ec[3]), 32'h3);
        step();
        chk("t6_saturate_hold", 32'(o_ec[3]), 32'h3);
        idle(); step();

        // West-first at (3,3).
        s_vld[2][0] = 1'b1; s_dst[2][0] = 8'h0E;
        s_vld[2][1] = 1'b1; s_dst[2][1] = 8'h31;
        step();
        chk("t4_es_pref", 32'(o_pref[2][4:0]), 32'h06);
        chk("t4_w_pref", 32'(o_pref[2][9:5]), 32'h08);
        idle(); step();

        // Backpressure on channel 1 of the lookahead instance.
        s_ordy[0][1] = 1'b0; s_vld[0][1] = 1'b1; s_dst[0][1] = 8'h2C; s_dir[0][1] = 2'd1;
        step();
        chk("t5_first_pref", 32'(o_pref[0][9:5]), 32'h02);
        chk("t5_stall_ready", 32'(o_rdy[0][1]), 32'h0);
        s_dst[0][1] = 8'h13;
        step();
        chk("t5_hold_pref_a", 32'(o_pref[0][9:5]), 32'h02);
        step();
        chk("t5_hold_pref_b", 32'(o_pref[0][9:5]), 32'h02);
        chk("t5_hold_valid", 32'(o_vld[0][1]), 32'h1);
        s_ordy[0][1] = 1'b1;
        #1;
        chk("t5_release_ready", 32'(o_rdy[0][1]), 32'h1);
        step();
        chk("t5_second_pref", 32'(o_pref[0][9:5]), 32'h10);
        chk("t5_second_valid", 32'(o_vld[0][1]), 32'h1);
        s_vld[0][1] = 1'b0;
        step();
        chk("t5_no_duplicate", 32'(o_vld[0][1]), 32'h0);
        idle(); step();

        // Reset while every channel holds a result.
        s_vld[0] = 4'hF; s_vld[3] = 4'hF; s_ordy[0] = 4'h0; s_ordy[3] = 4'h0;
        for (int c = 0; c < 4; c++) begin s_dst[0][c] = 8'(c * 9); s_dir[3][c] = 2'd3; end
        step();
        chk("t6_all_valid", 32'(o_vld[0]), 32'hF);
        rst = 1'b1;
        step();
        chk("t6_reset_valid", 32'(o_vld[0]), 32'h0);
        chk("t6_reset_count", 32'(o_ec[3]), 32'h0);
        rst = 1'b0;
        idle(); step();

        repeat (3000) begin
            for (int k = 0; k < NI; k++) begin
                s_vld[k] = 4'($urandom);
                for (int c = 0; c < 4; c++) begin
                    s_ordy[k][c] = ($urandom_range(0, 3) != 0);
                    s_dst[k][c]  = 8'($urandom);
                    s_dir[k][c]  = 2'($urandom);
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
